axi_slave_read_burst_engine: RTL and testbench

Parametrised AXI4 read-side slave that accepts one read burst at a time and generates per-beat addresses for FIXED, INCR and WRAP bursts of any legal ARSIZE. It drives a synchronous one-cycle-latency memory port and buffers returned words in a 2-entry skid FIFO, so RREADY back-pressure never loses data and full throughput is one beat per cycle. It also returns RID, OKAY/SLVERR responses and RLAST. It sits between the AXI interconnect and the instruction/data RAM, pairing with the write-channel slave.

---
 rtl/axi_slave_read_burst_engine.sv | 171 +++++++++++++++++
 tb/tb_axi_slave_read_burst_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_read_burst_engine.sv
// AXI4 read-channel slave: one burst at a time, FIXED/INCR/WRAP beat addressing,
// one-cycle-latency memory port and a 2-entry skid FIFO in front of the R channel.
module axi_slave_read_burst_engine #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           LEN_WIDTH  = 8,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter int unsigned           MEM_BYTES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned           BYTES     = DATA_WIDTH / 8;
    localparam logic [2:0]            MAX_SIZE  = 3'($clog2(BYTES));
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_END   = {1'b0, MEM_BASE} + (ADDR_WIDTH+1)'(MEM_BYTES);

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;

    state_t                state, state_next;
    logic                  ready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q, step_q, wrap_mask_q, addr_next;
    logic [LEN_WIDTH-1:0]  len_q, sent;
    logic [LEN_WIDTH:0]    issued;
    burst_t                burst_q;
    logic                  burst_err_q;

    // One read (or error slot) is in flight for exactly one cycle.
    logic                  pend, pend_err;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_err;
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count, occupancy;

    logic [ADDR_WIDTH-1:0] ar_step;
    logic                  ar_len_ok, ar_err;
    logic                  beat_err, issue, pop, push, pop_fifo, head_err;

    always_comb begin
        ar_step   = ADDR_WIDTH'(1) << ARSIZE;
        ar_len_ok = (ARLEN == LEN_WIDTH'(1)) || (ARLEN == LEN_WIDTH'(3)) ||
                    (ARLEN == LEN_WIDTH'(7)) || (ARLEN == LEN_WIDTH'(15));
        ar_err    = (ARBURST == RSVD) || (ARSIZE > MAX_SIZE) ||
                    ((ARBURST == WRAP) &&
                     (!ar_len_ok || ((ARADDR & (ar_step - ADDR_WIDTH'(1))) != '0)));
    end

    assign beat_err  = burst_err_q || (addr_q < MEM_BASE) || ({1'b0, addr_q} >= MEM_END);
    assign occupancy = count + {1'b0, pend};
    assign issue     = (state == BURST) && (issued <= {1'b0, len_q}) && (occupancy < 2'd2);
    assign mem_raddr = addr_q & ~LANE_MASK;

    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            INCR:    addr_next = addr_q + step_q;
            WRAP:    addr_next = (addr_q & ~wrap_mask_q) | ((addr_q + step_q) & wrap_mask_q);
            default: addr_next = addr_q;
        endcase
    end

    // Output side: FIFO head first, otherwise the word returning this cycle.
    assign RVALID   = (count != 2'd0) || pend;
    assign head_err = (count != 2'd0) ? fifo_err[rd_ptr] : pend_err;
    assign RDATA    = (count != 2'd0) ? fifo_data[rd_ptr] :
                      ((pend && !pend_err) ? mem_rdata : '0);
    assign RRESP    = (RVALID && head_err) ? 2'b10 : 2'b00;
    assign RLAST    = RVALID && (sent == len_q);
    assign RID      = id_q;
    assign pop      = RVALID && RREADY;
    assign pop_fifo = (count != 2'd0) && RREADY;
    assign push     = pend && ((count != 2'd0) || !RREADY);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        ARREADY    = 1'b0;
        mem_ren    = 1'b0;
        case (state)
            IDLE: begin
                ARREADY = ready_q;
                if (ARVALID && ready_q) state_next = BURST;
            end
            BURST: begin
                mem_ren = issue && !beat_err;
                if (pop && RLAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= 1'b1;
        end
    end

    // NOTE: the two FIFO words are reset too; it is cheap and keeps RDATA defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q        <= '0;
            addr_q      <= '0;
            step_q      <= '0;
            wrap_mask_q <= '0;
            len_q       <= '0;
            burst_q     <= FIXED;
            burst_err_q <= 1'b0;
            issued      <= '0;
            sent        <= '0;
            pend        <= 1'b0;
            pend_err    <= 1'b0;
            fifo_err    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
        end else begin
            if (ARVALID && ARREADY) begin
                id_q        <= ARID;
                addr_q      <= ARADDR;
                step_q      <= ar_step;
                wrap_mask_q <= ((ADDR_WIDTH'(ARLEN) + ADDR_WIDTH'(1)) << ARSIZE) - ADDR_WIDTH'(1);
                len_q       <= ARLEN;
                burst_q     <= burst_t'(ARBURST);
                burst_err_q <= ar_err;
                issued      <= '0;
                sent        <= '0;
            end
            if (issue) begin
                issued <= issued + 1'b1;
                addr_q <= addr_next;
            end
            pend     <= issue;
            pend_err <= issue && beat_err;
            if (pop) sent <= sent + 1'b1;
            if (push) begin
                fifo_data[wr_ptr] <= pend_err ? '0 : mem_rdata;
                fifo_err[wr_ptr]  <= pend_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop_fifo) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_fifo};
        end
    end

endmodule

// File: tb/tb_axi_slave_read_burst_engine.sv
// Directed bench: a table of bursts with hand-computed beat addresses and responses,
// plus hand-written RREADY-stall and mid-burst reset sequences.
module tb_axi_slave_read_burst_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;

    axi_slave_read_burst_engine dut (
        .clk(clk), .rst_n(rst_n),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [7:0]       exp_err;
        logic [7:0][31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } ren_t;

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    beat_t beat_q[$];
    ren_t  ren_q[$];
    int    ren_cnt = 0;
    int    ok_cnt = 0;
    bit    prev_stall = 1'b0;
    beat_t prev;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hA500_0000 | (a & 32'h00FF_FFFF);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ren) mem_rdata <= mdata(mem_raddr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            ren_cnt    = 0;
            ok_cnt     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_rvalid", RVALID, 1);
                check("stall_payload", {RDATA, RRESP, RLAST, RID},
                      {prev.data, prev.resp, prev.last, prev.id});
            end
            if (mem_ren) begin
                check("pending_lt2", (ren_cnt - ok_cnt) < 2, 1);
                ren_cnt++;
                ren_q.push_back('{mem_raddr, cyc});
            end
            if (RVALID) check("arready_busy", ARREADY, 0);
            if (RVALID && RREADY) begin
                beat_q.push_back('{RDATA, RRESP, RLAST, RID, cyc});
                if (RRESP == 2'b00) ok_cnt++;
            end
            prev_stall = RVALID && !RREADY;
            prev       = '{RDATA, RRESP, RLAST, RID, cyc};
        end
    end

    function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [7:0] err,
                                input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.exp_err = err;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
        v.exp_addr[4] = a4; v.exp_addr[5] = a5; v.exp_addr[6] = a6; v.exp_addr[7] = a7;
        return v;
    endfunction

    task automatic drive_ar(input vec_t v, output int t_ar);
        bit got;
        beat_q.delete();
        ren_q.delete();
        @(posedge clk); #1;
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARBURST = v.burst;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        got = 1'b0;
        t_ar = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (ARREADY) begin
                got  = 1'b1;
                t_ar = cyc;
            end
            @(posedge clk); #1;
        end
        ARVALID = 1'b0;
        check("ar_accept", got, 1);
    endtask

    task automatic run_burst(input vec_t v, input logic [3:0] pat, output int t_ar);
        int k;
        drive_ar(v, t_ar);
        k = 0;
        while (beat_q.size() < int'(v.len) + 1 && k < 200) begin
            RREADY = pat[k % 4];
            k++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("arready_reassert", ARREADY, 1);
    endtask

    task automatic verify(input int idx, input vec_t v, input int t_ar, input bit timed);
        int n;
        logic [31:0] exp_ren[$];
        n = int'(v.len) + 1;
        check($sformatf("v%0d_beat_count", idx), beat_q.size(), n);
        for (int k = 0; k < n && k < beat_q.size(); k++) begin
            check($sformatf("v%0d_rdata%0d", idx, k), beat_q[k].data,
                  v.exp_err[k] ? 32'h0 : mdata(v.exp_addr[k]));
            check($sformatf("v%0d_rresp%0d", idx, k), beat_q[k].resp, v.exp_err[k] ? 2'b10 : 2'b00);
            check($sformatf("v%0d_rlast%0d", idx, k), beat_q[k].last, k == n - 1);
            check($sformatf("v%0d_rid%0d", idx, k), beat_q[k].id, v.id);
        end
        for (int k = 0; k < n; k++) if (!v.exp_err[k]) exp_ren.push_back(v.exp_addr[k]);
        check($sformatf("v%0d_ren_count", idx), ren_q.size(), exp_ren.size());
        for (int k = 0; k < exp_ren.size() && k < ren_q.size(); k++)
            check($sformatf("v%0d_mem_raddr%0d", idx, k), ren_q[k].addr, exp_ren[k]);
        if (timed && beat_q.size() == n) begin
            check($sformatf("v%0d_first_rvalid_cyc", idx), beat_q[0].cyc, t_ar + 2);
            check($sformatf("v%0d_last_beat_cyc", idx), beat_q[n-1].cyc, t_ar + 1 + n);
            if (!v.exp_err[0] && ren_q.size() > 0)
                check($sformatf("v%0d_first_ren_cyc", idx), ren_q[0].cyc, t_ar + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   t_ar;
        int   waited;

        vecs[0] = mk(4'h3, 32'h10,  8'd3, 3'd2, 2'b01, 8'h00, 32'h10, 32'h14, 32'h18, 32'h1C, 0, 0, 0, 0);
        vecs[1] = mk(4'h5, 32'h38,  8'd3, 3'd2, 2'b10, 8'h00, 32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0);
        vecs[2] = mk(4'h1, 32'h20,  8'd2, 3'd2, 2'b00, 8'h00, 32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0);
        vecs[3] = mk(4'h7, 32'hFFC, 8'd1, 3'd2, 2'b01, 8'h02, 32'hFFC, 32'h1000, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(4'h2, 32'h40,  8'd2, 3'd2, 2'b11, 8'h07, 32'h40, 32'h44, 32'h48, 0, 0, 0, 0, 0);
        vecs[5] = mk(4'h9, 32'h102, 8'd0, 3'd1, 2'b01, 8'h00, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(4'h4, 32'h0,   8'd1, 3'd3, 2'b01, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(4'h6, 32'h0,   8'd2, 3'd2, 2'b10, 8'h07, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8] = mk(4'hC, 32'h1E,  8'd7, 3'd1, 2'b10, 8'h00,
                     32'h1C, 32'h10, 32'h10, 32'h14, 32'h14, 32'h18, 32'h18, 32'h1C);
        vecs[9] = mk(4'hE, 32'h3A,  8'd3, 3'd2, 2'b10, 8'h0F, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_arready", ARREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_outputs", {RDATA, RID, RRESP, mem_raddr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_arready", ARREADY, 1);

        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i], 4'b1111, t_ar);
            verify(i, vecs[i], t_ar, 1'b1);
        end

        // RREADY toggled 1,0,0,1 over an 8-beat INCR burst.
        v = mk(4'hB, 32'h80, 8'd7, 3'd2, 2'b01, 8'h00,
               32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h98, 32'h9C);
        run_burst(v, 4'b1001, t_ar);
        verify(10, v, t_ar, 1'b0);

        // Asynchronous reset while beat 2 of an 8-beat burst is presented.
        v = mk(4'h3, 32'h300, 8'd7, 3'd2, 2'b01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_ar(v, t_ar);
        RREADY = 1'b1;
        waited = 0;
        while (beat_q.size() < 2 && waited < 50) begin
            waited++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pre_reset_rvalid", RVALID, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", RVALID, 0);
        check("midrst_arready", ARREADY, 0);
        check("midrst_mem_ren", mem_ren, 0);
        check("midrst_rlast", RLAST, 0);
        check("midrst_outputs", {RDATA, RID, RRESP, mem_raddr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_arready", ARREADY, 1);
        v = mk(4'hA, 32'h200, 8'd0, 3'd2, 2'b01, 8'h00, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        run_burst(v, 4'b1111, t_ar);
        verify(11, v, t_ar, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
